i2c_master_writer: RTL

I2C_MASTER_WRITER -- requirements
Module: i2c_master_writer

---
 rtl/i2c_master_writer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/i2c_master_writer.sv
// Single-byte I2C write master: START, 7-bit address + W, one data byte, STOP.
// SCL is push-pull with no stretching; SDA is open-drain (drives 0 or Z).
module i2c_master_writer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] slave_addr,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       scl,
  inout  wire        sda
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP
  } state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_div;
  logic [1:0]  r_phase;
  logic [2:0]  r_bit;
  logic [7:0]  r_addr_byte;
  logic [7:0]  r_data_byte;
  logic        r_done;
  logic        r_ack_err;

  logic        w_tick, w_slot_end, w_accept, w_ack_smp;
  logic        w_scl, w_sda_oe;

  assign w_tick     = (r_state != S_IDLE) && (r_div == 8'(CLK_DIV - 1));
  assign w_slot_end = w_tick && (r_phase == 2'd3);
  // done's cycle is already IDLE, so it is masked to drop a start in that cycle
  assign w_accept   = start && (r_state == S_IDLE) && !r_done;
  assign w_ack_smp  = ((r_state == S_ADDR_ACK) || (r_state == S_DATA_ACK)) &&
                      (r_phase == 2'd2) && (r_div == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_accept)   w_next = S_START;
      S_START:    if (w_slot_end) w_next = S_ADDR;
      S_ADDR:     if (w_slot_end && r_bit == 3'd0) w_next = S_ADDR_ACK;
      // r_ack_err is cleared on acceptance, so here it reflects this slot's sample
      S_ADDR_ACK: if (w_slot_end) w_next = r_ack_err ? S_STOP : S_DATA;
      S_DATA:     if (w_slot_end && r_bit == 3'd0) w_next = S_DATA_ACK;
      S_DATA_ACK: if (w_slot_end) w_next = S_STOP;
      S_STOP:     if (w_slot_end) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_scl    = 1'b1;
    w_sda_oe = 1'b0;
    case (r_state)
      S_START: begin
        w_scl    = (r_phase != 2'd3);
        w_sda_oe = r_phase[1];
      end
      S_ADDR: begin
        w_scl    = (r_phase == 2'd1) || (r_phase == 2'd2);
        w_sda_oe = ~r_addr_byte[r_bit];
      end
      S_DATA: begin
        w_scl    = (r_phase == 2'd1) || (r_phase == 2'd2);
        w_sda_oe = ~r_data_byte[r_bit];
      end
      S_ADDR_ACK, S_DATA_ACK: begin
        w_scl    = (r_phase == 2'd1) || (r_phase == 2'd2);
        w_sda_oe = 1'b0;
      end
      S_STOP: begin
        w_scl    = (r_phase != 2'd0);
        w_sda_oe = (r_phase != 2'd3);
      end
      default: begin
        w_scl    = 1'b1;
        w_sda_oe = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= '0;
      r_phase     <= '0;
      r_bit       <= 3'd7;
      r_addr_byte <= '0;
      r_data_byte <= '0;
      r_done      <= 1'b0;
      r_ack_err   <= 1'b0;
    end else begin
      r_done <= w_slot_end && (r_state == S_STOP);
      if (r_state == S_IDLE) begin
        r_div   <= '0;
        r_phase <= '0;
        r_bit   <= 3'd7;
        if (w_accept) begin
          r_addr_byte <= {slave_addr, 1'b0};
          r_data_byte <= data_in;
          r_ack_err   <= 1'b0;
        end
      end else begin
        r_div <= w_tick ? 8'd0 : r_div + 8'd1;
        if (w_tick) r_phase <= r_phase + 2'd1;
        // 7..0 down-count wraps back to 7 ready for the next byte
        if (w_slot_end && ((r_state == S_ADDR) || (r_state == S_DATA)))
          r_bit <= r_bit - 3'd1;
        if (w_ack_smp && sda) r_ack_err <= 1'b1;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign ack_error = r_ack_err;
  assign scl       = w_scl;
  assign sda       = w_sda_oe ? 1'b0 : 1'bz;

endmodule
